// File: rtl/cmd_proc_q.sv
// Queued command processor: buffers up to DEPTH commands from the UART and runs them
// one at a time against cal / navigate / maze_solve, with coded responses and a watchdog.
module cmd_proc_q #(
  parameter int DEPTH  = 4,
  parameter int HDNG_W = 12,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cmd,
  input  logic              cmd_rdy,
  output logic              clr_cmd_rdy,
  output logic              send_resp,
  output logic [7:0]        resp,
  output logic              strt_cal,
  input  logic              cal_done,
  output logic              in_cal,
  output logic              strt_hdng,
  output logic              strt_mv,
  input  logic              mv_cmplt,
  output logic [HDNG_W-1:0] dsrd_hdng,
  output logic              stp_lft,
  output logic              stp_rght,
  output logic              cmd_md,
  input  logic              sol_cmplt,
  output logic              busy,
  output logic [$clog2(DEPTH):0] q_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [7:0] RSP_TMO = 8'hBB;
  localparam logic [7:0] RSP_ABT = 8'hAB;

  typedef struct packed {
    logic [2:0]  op;
    logic [12:0] arg;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, CAL, HDNG, MOVE, SOLVE} state_t;

  state_t           state, state_nxt;
  cmd_t             q_mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic [TMO_W-1:0] wdog;
  logic             ee_pend;

  logic [2:0] op;
  logic       full, push, pop, is_abt, is_bad;
  logic       done, tmo;
  logic       unused_head;

  // ---- intake decode ----
  assign op     = cmd[15:13];
  assign full   = (cnt == CW'(DEPTH));
  assign is_abt = cmd_rdy & (op == 3'b111);
  assign is_bad = cmd_rdy & op[2] & (op != 3'b111);
  assign push   = cmd_rdy & ~op[2] & ~full;
  assign clr_cmd_rdy = is_abt | is_bad | push;

  assign head        = q_mem[rd_ptr];
  assign unused_head = ^{head.op[2], head.arg};

  assign busy   = (state != IDLE);
  assign cmd_md = (state != SOLVE);
  assign q_cnt  = cnt;

  // ---- executor next state / pulses ----
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    strt_cal  = 1'b0;
    strt_hdng = 1'b0;
    strt_mv   = 1'b0;
    in_cal    = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (cnt != '0 && !is_abt) begin
          pop = 1'b1;
          case (head.op[1:0])
            2'b00:   begin strt_cal  = 1'b1; state_nxt = CAL;  end
            2'b01:   begin strt_hdng = 1'b1; state_nxt = HDNG; end
            2'b10:   begin strt_mv   = 1'b1; state_nxt = MOVE; end
            default: state_nxt = SOLVE;
          endcase
        end
      end
      CAL: begin
        in_cal = ~cal_done;
        if (cal_done)   begin done = 1'b1; state_nxt = IDLE; end
        else if (&wdog) begin tmo  = 1'b1; state_nxt = IDLE; end
      end
      HDNG, MOVE: begin
        if (mv_cmplt)   begin done = 1'b1; state_nxt = IDLE; end
        else if (&wdog) begin tmo  = 1'b1; state_nxt = IDLE; end
      end
      SOLVE: begin
        if (sol_cmplt) begin done = 1'b1; state_nxt = IDLE; end
      end
      default: state_nxt = IDLE;
    endcase
    if (is_abt) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Watchdog restarts on every state change; SOLVE has no time limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            wdog <= '0;
    else if (state_nxt != state)                           wdog <= '0;
    else if (state == CAL || state == HDNG || state == MOVE) wdog <= wdog + 1'b1;
  end

  // ---- command queue ----
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (is_abt) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // ---- navigate parameters, held until the next heading/move pop ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsrd_hdng <= '0;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
    end else begin
      if (strt_hdng) dsrd_hdng <= head.arg[HDNG_W-1:0];
      if (strt_mv) begin
        stp_lft  <= head.arg[1];
        stp_rght <= head.arg[0];
      end
    end
  end

  // ---- response arbiter: abort > completion/timeout > error ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_resp <= 1'b0;
      resp      <= 8'h00;
      ee_pend   <= 1'b0;
    end else begin
      send_resp <= 1'b0;
      if (is_abt) begin
        send_resp <= 1'b1;
        resp      <= RSP_ABT;
        ee_pend   <= 1'b0;
      end else if (done | tmo) begin
        send_resp <= 1'b1;
        resp      <= done ? RSP_ACK : RSP_TMO;
        ee_pend   <= ee_pend | is_bad;
      end else if (ee_pend | is_bad) begin
        // a fresh error arriving with one already pending is dropped here
        send_resp <= 1'b1;
        resp      <= RSP_ERR;
        ee_pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_proc_q.sv
// Directed bench for cmd_proc_q: a per-cycle vector table plus hand-written sequences
// for back-pressure, abort, solve mode and watchdog timeout.
module tb_cmd_proc_q;
  localparam int DEPTH  = 4;
  localparam int HDNG_W = 12;
  localparam int TMO_W  = 6;

  logic        clk, rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy, cal_done, mv_cmplt, sol_cmplt;
  logic        clr_cmd_rdy, send_resp, strt_cal, in_cal, strt_hdng, strt_mv;
  logic [7:0]  resp;
  logic [HDNG_W-1:0] dsrd_hdng;
  logic        stp_lft, stp_rght, cmd_md, busy;
  logic [2:0]  q_cnt;

  cmd_proc_q #(.DEPTH(DEPTH), .HDNG_W(HDNG_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .strt_cal(strt_cal), .cal_done(cal_done),
    .in_cal(in_cal), .strt_hdng(strt_hdng), .strt_mv(strt_mv), .mv_cmplt(mv_cmplt),
    .dsrd_hdng(dsrd_hdng), .stp_lft(stp_lft), .stp_rght(stp_rght), .cmd_md(cmd_md),
    .sol_cmplt(sol_cmplt), .busy(busy), .q_cnt(q_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        cr;
    logic [15:0] c;
    logic        cd, mc, sc;
    logic        clr;
    logic [2:0]  strt;   // {cal, hdng, mv}
    logic        ic, snd;
    logic [7:0]  rsp;
    logic        bsy, md;
    logic [2:0]  qc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic cr, logic [15:0] c, logic cd, logic mc, logic sc,
                              logic clr, logic [2:0] strt, logic ic, logic snd,
                              logic [7:0] rsp, logic bsy, logic md, logic [2:0] qc);
    vec_t v;
    v.cr = cr; v.c = c; v.cd = cd; v.mc = mc; v.sc = sc;
    v.clr = clr; v.strt = strt; v.ic = ic; v.snd = snd;
    v.rsp = rsp; v.bsy = bsy; v.md = md; v.qc = qc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [15:0] c, input logic cd,
                       input logic mc, input logic sc);
    cmd_rdy = cr; cmd = c; cal_done = cd; mv_cmplt = mc; sol_cmplt = sc;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    drive(0, 16'h0000, 0, 0, 0);
    tick(); tick();
    #1;
    chk("reset_regs", {send_resp, resp, busy, cmd_md, q_cnt, stp_lft, stp_rght},
                      {1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0});
    chk("reset_hdng", dsrd_hdng, 12'h000);
    tick();
    rst_n = 1'b1;

    //        cr  cmd       cd mc sc   clr strt  ic snd rsp   bsy md qc
    vt.push_back(mk(1, 16'h2123, 0, 0, 0,  1, 3'b000, 0, 0, 8'h00, 0, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b010, 0, 0, 8'h00, 0, 1, 3'd1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 0, 8'h00, 1, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0,  0, 3'b000, 0, 0, 8'h00, 1, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 1, 8'hA5, 0, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 0, 8'hA5, 0, 1, 3'd0));
    vt.push_back(mk(1, 16'h0000, 0, 0, 0,  1, 3'b000, 0, 0, 8'hA5, 0, 1, 3'd0));
    vt.push_back(mk(1, 16'h2045, 0, 0, 0,  1, 3'b100, 0, 0, 8'hA5, 0, 1, 3'd1));
    vt.push_back(mk(1, 16'h4002, 0, 0, 0,  1, 3'b000, 1, 0, 8'hA5, 1, 1, 3'd1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 1, 0, 8'hA5, 1, 1, 3'd2));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 3'b000, 0, 0, 8'hA5, 1, 1, 3'd2));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b010, 0, 1, 8'hA5, 0, 1, 3'd2));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 0, 8'hA5, 1, 1, 3'd1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0,  0, 3'b000, 0, 0, 8'hA5, 1, 1, 3'd1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b001, 0, 1, 8'hA5, 0, 1, 3'd1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 0, 8'hA5, 1, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0,  0, 3'b000, 0, 0, 8'hA5, 1, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 1, 8'hA5, 0, 1, 3'd0));
    vt.push_back(mk(1, 16'h0000, 0, 0, 0,  1, 3'b000, 0, 0, 8'hA5, 0, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b100, 0, 0, 8'hA5, 0, 1, 3'd1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 1, 0, 8'hA5, 1, 1, 3'd0));
    vt.push_back(mk(1, 16'h8000, 1, 0, 0,  1, 3'b000, 0, 0, 8'hA5, 1, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 1, 8'hA5, 0, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 1, 8'hEE, 0, 1, 3'd0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0,  0, 3'b000, 0, 0, 8'hEE, 0, 1, 3'd0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].cr, vt[i].c, vt[i].cd, vt[i].mc, vt[i].sc);
      #1;
      chk($sformatf("row%0d", i),
          {clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, in_cal, send_resp, resp, busy, cmd_md, q_cnt},
          {vt[i].clr, vt[i].strt, vt[i].ic, vt[i].snd, vt[i].rsp, vt[i].bsy, vt[i].md, vt[i].qc});
      if (i == 5)  chk("hdng_123", dsrd_hdng, 12'h123);
      if (i == 15) chk("mv_params", {stp_lft, stp_rght, dsrd_hdng}, {1'b1, 1'b0, 12'h045});
      tick();
    end

    // back-pressure: executor parked in CAL while the queue fills
    drive(1, 16'h0000, 0, 0, 0); tick();
    drive(1, 16'h2001, 0, 0, 0); tick();
    drive(1, 16'h2002, 0, 0, 0); tick();
    drive(1, 16'h2003, 0, 0, 0); tick();
    drive(1, 16'h2004, 0, 0, 0); tick();
    drive(1, 16'h2005, 0, 0, 0); #1;
    chk("full_cnt_clr", {q_cnt, clr_cmd_rdy}, {3'd4, 1'b0});
    tick(); #1;
    chk("full_held", clr_cmd_rdy, 1'b0);
    tick();
    drive(1, 16'h2005, 1, 0, 0); #1;
    chk("full_caldone", clr_cmd_rdy, 1'b0);
    tick();
    drive(1, 16'h2005, 0, 0, 0); #1;
    chk("full_pop_no_relief", {strt_hdng, clr_cmd_rdy}, {1'b1, 1'b0});
    tick(); #1;
    chk("full_relieved", {q_cnt, clr_cmd_rdy}, {3'd3, 1'b1});
    tick();
    drive(1, 16'hE000, 0, 0, 0); #1;
    chk("abort_clr_full", {q_cnt, clr_cmd_rdy}, {3'd4, 1'b1});
    tick();
    drive(0, 16'h0000, 0, 0, 0); #1;
    chk("abort_flush", {busy, q_cnt, send_resp, resp, dsrd_hdng}, {1'b0, 3'd0, 1'b1, 8'hAB, 12'h001});
    tick();

    // abort while moving with two queued, after an error response
    drive(1, 16'h4003, 0, 0, 0); tick();
    drive(1, 16'h0000, 0, 0, 0); #1;
    chk("mv_start", strt_mv, 1'b1);
    tick();
    drive(1, 16'h0000, 0, 0, 0); tick();
    drive(1, 16'hA000, 0, 0, 0); #1;
    chk("mv_two_queued", {q_cnt, busy, stp_lft, stp_rght, clr_cmd_rdy}, {3'd2, 1'b1, 1'b1, 1'b1, 1'b1});
    tick();
    drive(0, 16'h0000, 0, 0, 0); #1;
    chk("bad_op_ee", {send_resp, resp, q_cnt}, {1'b1, 8'hEE, 3'd2});
    tick();
    drive(1, 16'hE000, 0, 0, 0); #1;
    chk("abort_mv_clr", clr_cmd_rdy, 1'b1);
    tick();
    drive(0, 16'h0000, 0, 0, 0); #1;
    chk("abort_mv", {busy, q_cnt, send_resp, resp, cmd_md, strt_cal, stp_lft},
                    {1'b0, 3'd0, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b1});
    tick();

    // solve hands navigate to maze_solve
    drive(1, 16'h6000, 0, 0, 0); tick();
    drive(0, 16'h0000, 0, 0, 0); #1;
    chk("solve_pop", {cmd_md, busy}, {1'b1, 1'b0});
    tick(); #1;
    chk("solve_entry", {cmd_md, busy}, {1'b0, 1'b1});
    tick();
    drive(0, 16'h0000, 0, 0, 1); #1;
    chk("solve_cmplt", cmd_md, 1'b0);
    tick();
    drive(0, 16'h0000, 0, 0, 0); #1;
    chk("solve_ack", {send_resp, resp, cmd_md, busy}, {1'b1, 8'hA5, 1'b1, 1'b0});
    tick();

    // watchdog: heading never completes, queued cal runs afterwards
    drive(1, 16'h2100, 0, 0, 0); tick();
    drive(1, 16'h0000, 0, 0, 0); #1;
    chk("tmo_hdng_start", strt_hdng, 1'b1);
    tick();
    drive(0, 16'h0000, 0, 0, 0); #1;
    chk("tmo_busy", {busy, q_cnt}, {1'b1, 3'd1});
    n = 0;
    while (n < 200) begin
      tick(); #1;
      n++;
      if (send_resp) break;
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_resp", {send_resp, resp, strt_cal, q_cnt}, {1'b1, 8'hBB, 1'b1, 3'd1});
    tick(); #1;
    chk("tmo_next_cal", {in_cal, busy, q_cnt}, {1'b1, 1'b1, 3'd0});
    tick();
    drive(0, 16'h0000, 1, 0, 0); tick();
    drive(0, 16'h0000, 0, 0, 0); #1;
    chk("tmo_cal_ack", {send_resp, resp, busy}, {1'b1, 8'hA5, 1'b0});
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
